uart_to_json: RTL
=================

UART_TO_JSON -- requirements
Module: uart_to_json

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434; clocks per UART bit (115200 baud at 50 MHz).
REQ-002 SHALL have parameter MAX_LEN, default 32; capacity of the frame buffer in bytes.
REQ-003 SHALL have port clk, input, 1 bit; the single clock for the block; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; asynchronous, active-high reset.
REQ-005 SHALL have port uart_in, input, 1 bit; UART serial line, idle high, 8N1.
REQ-006 SHALL have port json_str, output, array [0:MAX_LEN-1] of 8 bits; the received JSON frame.
REQ-007 SHALL have port json_len, output, 8 bits; count of bytes stored in json_str.
REQ-008 SHALL have port done, output, 1 bit; one-cycle pulse when a complete frame is stored.
REQ-009 SHALL have port busy, output, 1 bit; high while a frame is being collected.
REQ-010 SHALL have port error, output, 1 bit; one-cycle pulse on a framing error or an overflow.

Function
REQ-011 SHALL pass uart_in through a 2-flop synchronizer, resetting to 1, before any use.
REQ-012 SHALL run the RX FSM IDLE->START->DATA->STOP->IDLE, with a bit-clock counter and a bit index.
REQ-013 IDLE: on a synchronized high-to-low transition, SHALL clear the counter and enter START.
REQ-014 START: after CLKS_PER_BIT/2 clocks, SHALL enter DATA if the line is low, else return to IDLE (glitch reject, no byte, no error).
REQ-015 DATA: SHALL sample 8 bits at CLKS_PER_BIT intervals from the start-bit midpoint, LSB first, then enter STOP.
REQ-016 STOP: after CLKS_PER_BIT clocks, a high line SHALL give a one-cycle internal byte strobe; a low line SHALL pulse error and discard the byte; either case SHALL return to IDLE.
REQ-017 SHALL run the frame FSM with states HUNT and COLLECT; busy SHALL equal (state==COLLECT).
REQ-018 HUNT: SHALL discard strobed bytes other than 0x7B '{'.
REQ-019 HUNT: on 0x7B, SHALL write json_str[0]=0x7B, set json_len=1 and enter COLLECT.
REQ-020 COLLECT: each strobed byte SHALL be written to json_str[json_len], and json_len SHALL increment.
REQ-021 COLLECT: a 0x7D '}' that terminates the frame (REQ-031/032) SHALL be stored, pulse done in the cycle after the strobe, and return to HUNT.
REQ-022 json_str and json_len SHALL hold stable from done until the next accepted '{'.
REQ-023 COLLECT: a byte arriving when json_len==MAX_LEN SHALL not be stored; the block SHALL pulse error, clear json_len to 0 and enter HUNT.
REQ-024 A '}' arriving as byte number MAX_LEN SHALL complete the frame normally with json_len=MAX_LEN.
REQ-025 A framing error in COLLECT SHALL clear json_len to 0, return to HUNT and not pulse done; a framing error in HUNT SHALL pulse error only.
REQ-026 done and error SHALL never assert in the same cycle.

Reset
REQ-027 While rst=1: the RX FSM SHALL be IDLE, the frame FSM HUNT, counters 0, json_len=0, every json_str entry 0x00, and done, busy and error 0.
REQ-028 Reset mid-byte or mid-frame SHALL discard all partial data; the next frame SHALL need a fresh '{'.

Configuration
REQ-029 Macro UART_TO_JSON_NEST_EN SHALL select brace nesting support.
REQ-030 With UART_TO_JSON_NEST_EN, a 3-bit depth counter SHALL be set to 1 on the opening '{', increment on each stored '{' and decrement on each stored '}'.
REQ-031 With UART_TO_JSON_NEST_EN, the frame SHALL terminate on the '}' that brings depth to 0; a '{' at depth 7 SHALL pulse error and enter HUNT.
REQ-032 Without UART_TO_JSON_NEST_EN, there SHALL be no depth counter; the first '}' in COLLECT SHALL terminate the frame, and a '{' in COLLECT SHALL be stored as an ordinary byte.

Verification
REQ-033 Send `{"a":1}` -> one done pulse, json_len=7, json_str[0]=0x7B, json_str[6]=0x7D, error never high.
REQ-034 Send "xy{}" -> done with json_len=2 and json_str[0..1]=0x7B,0x7D; busy high only between '{' and done.
REQ-035 Drive a 100-clock low glitch on uart_in, then send '{' with the stop bit low -> no byte, error pulses once, busy stays 0.
REQ-036 Send '{' then 32 'a' (0x61) -> error pulse at the 32nd 'a', json_len=0, state HUNT, no done.
REQ-037 Send `{"a":{"b":2}}` -> with NEST_EN, done after byte 13 with json_len=13; without NEST_EN, done after byte 12 with json_len=12.
REQ-038 Assert rst during byte 4 of a frame, release, then send "{}" -> all outputs 0 during reset, then done with json_len=2.

Source files
------------

// File: rtl/uart_to_json.sv
// rtl/uart_to_json.sv - 8N1 UART receiver that captures '{'..'}' delimited frames into a byte buffer.
// Optional brace nesting support is enabled with macro UART_TO_JSON_NEST_EN.
module uart_to_json #(
    parameter int CLKS_PER_BIT = 434,
    parameter int MAX_LEN      = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_in,
    output logic [7:0] json_str [0:MAX_LEN-1],
    output logic [7:0] json_len,
    output logic       done,
    output logic       busy,
    output logic       error
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int AW = $clog2(MAX_LEN);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [7:0]    LEN_MAX = 8'(MAX_LEN);
    localparam logic [7:0]    LBRACE  = 8'h7B;
    localparam logic [7:0]    RBRACE  = 8'h7D;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic {F_HUNT, F_COLLECT} frame_state_e;

    logic [1:0]   sync_q;
    logic         prev_q;
    logic         rx;
    rx_state_e    rx_state_q, rx_state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]   bit_idx_q, bit_idx_d;
    logic [7:0]   shift_q, shift_d;
    logic         byte_stb_q, byte_stb_d;
    logic         frame_err_q, frame_err_d;

    frame_state_e fstate_q, fstate_d;
    logic [7:0]   len_q, len_d;
    logic [7:0]   str_q [0:MAX_LEN-1];
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic         wr_en;
    logic [AW-1:0] wr_idx;
`ifdef UART_TO_JSON_NEST_EN
    logic [2:0]   depth_q, depth_d;
`endif

    assign rx = sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= 2'b11;
            prev_q      <= 1'b1;
            rx_state_q  <= RX_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            byte_stb_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], uart_in};
            prev_q      <= rx;
            rx_state_q  <= rx_state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            byte_stb_q  <= byte_stb_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_stb_d  = 1'b0;
        frame_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (prev_q && !rx) begin
                    cnt_d      = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d      = '0;
                    bit_idx_d  = '0;
                    rx_state_d = rx ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    shift_d   = {rx, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d       = '0;
                    rx_state_d  = RX_IDLE;
                    byte_stb_d  = rx;
                    frame_err_d = !rx;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Frame FSM reacts to the registered strobe, so done/error land one cycle after it.
    always_comb begin
        fstate_d = fstate_q;
        len_d    = len_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = len_q[AW-1:0];
`ifdef UART_TO_JSON_NEST_EN
        depth_d  = depth_q;
`endif
        if (frame_err_q) begin
            err_d = 1'b1;
            if (fstate_q == F_COLLECT) begin
                len_d    = '0;
                fstate_d = F_HUNT;
            end
        end else if (byte_stb_q) begin
            if (fstate_q == F_HUNT) begin
                if (shift_q == LBRACE) begin
                    wr_en    = 1'b1;
                    wr_idx   = '0;
                    len_d    = 8'd1;
                    fstate_d = F_COLLECT;
`ifdef UART_TO_JSON_NEST_EN
                    depth_d  = 3'd1;
`endif
                end
            end else if (len_q == LEN_MAX) begin
                err_d    = 1'b1;
                len_d    = '0;
                fstate_d = F_HUNT;
`ifdef UART_TO_JSON_NEST_EN
            end else if (shift_q == LBRACE && depth_q == 3'd7) begin
                err_d    = 1'b1;
                len_d    = '0;
                fstate_d = F_HUNT;
`endif
            end else begin
                wr_en = 1'b1;
                len_d = len_q + 8'd1;
`ifdef UART_TO_JSON_NEST_EN
                if (shift_q == LBRACE) begin
                    depth_d = depth_q + 3'd1;
                end else if (shift_q == RBRACE) begin
                    depth_d = depth_q - 3'd1;
                    if (depth_q == 3'd1) begin
                        done_d   = 1'b1;
                        fstate_d = F_HUNT;
                    end
                end
`else
                if (shift_q == RBRACE) begin
                    done_d   = 1'b1;
                    fstate_d = F_HUNT;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fstate_q <= F_HUNT;
            len_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef UART_TO_JSON_NEST_EN
            depth_q  <= '0;
`endif
            for (int i = 0; i < MAX_LEN; i++) str_q[i] <= 8'h00;
        end else begin
            fstate_q <= fstate_d;
            len_q    <= len_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef UART_TO_JSON_NEST_EN
            depth_q  <= depth_d;
`endif
            if (wr_en) str_q[wr_idx] <= shift_q;
        end
    end

    assign json_str = str_q;
    assign json_len = len_q;
    assign done     = done_q;
    assign error    = err_q;
    assign busy     = (fstate_q == F_COLLECT);

endmodule
